fix2flt_conv: RTL and testbench

- Converts one signed 8.8 fixed-point word (two's complement) into an IEEE-754 half-precision float, using a multi-cycle synthesizable FSM.
- Upstream neighbour of the float-to-fixed converter. It reads two bytes from data memory and writes the two result bytes to the locations the float-to-fixed stage consumes.
- Start/done handshake with the test bench. Normalization shifts one bit per cycle.

---
 rtl/fix2flt_conv.sv | 129 ++++++++++++
 tb/tb_fix2flt_conv.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fix2flt_conv.sv
// Signed 8.8 fixed-point to IEEE-754 half-precision converter, memory-mapped, start/done handshake.
// Optional macro FIX2FLT_RNE_EN selects round-to-nearest-even; default build truncates.
module fix2flt_conv #(
  parameter logic [7:0] IN_LO_ADDR  = 8'd0,
  parameter logic [7:0] OUT_LO_ADDR = 8'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic       busy,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata
);

  localparam int unsigned BIAS     = 15;
  localparam logic [4:0]  EXP_INIT = 5'(BIAS + 7);

  typedef enum logic [3:0] {
    IDLE, RD_LO, RD_HI, ABS, NORM, RND, WR_LO, WR_HI, FIN
  } state_t;

  state_t      state, state_nxt;
  logic        start_q;
  logic [15:0] v;
  logic        sign;
  logic [15:0] mag;
  logic [4:0]  exp_q;
  logic        zero;
  logic [15:0] result;

  logic [9:0]  mant_out;
  logic [4:0]  exp_out;
  logic [15:0] rnd_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      RD_LO: v[7:0]  <= mem_rdata;
      RD_HI: v[15:8] <= mem_rdata;
      ABS: begin
        sign  <= v[15];
        mag   <= v[15] ? (~v + 16'd1) : v;
        exp_q <= EXP_INIT;
        zero  <= 1'b0;
      end
      NORM: begin
        if (mag == '0) begin
          zero <= 1'b1;
        end else if (!mag[15]) begin
          mag   <= mag << 1;
          exp_q <= exp_q - 5'd1;
        end
      end
      RND:     result <= rnd_result;
      default: ;
    endcase
  end

  // mag[15] is the hidden bit once normalized; guard is mag[4], sticky is mag[3:0].
  always_comb begin
    mant_out = mag[14:5];
    exp_out  = exp_q;
`ifdef FIX2FLT_RNE_EN
    if (mag[4] && ((|mag[3:0]) || mag[5])) begin
      if (&mag[14:5]) begin
        mant_out = '0;
        exp_out  = exp_q + 5'd1;
      end else begin
        mant_out = mag[14:5] + 10'd1;
      end
    end
`endif
    rnd_result = zero ? '0 : {sign, exp_out, mant_out};
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE:  if (start_q && !start) state_nxt = RD_LO;
      RD_LO: begin
        mem_addr  = IN_LO_ADDR;
        state_nxt = RD_HI;
      end
      RD_HI: begin
        mem_addr  = IN_LO_ADDR + 8'd1;
        state_nxt = ABS;
      end
      ABS:   state_nxt = NORM;
      NORM:  if ((mag == '0) || mag[15]) state_nxt = RND;
      RND:   state_nxt = WR_LO;
      WR_LO: begin
        mem_we    = 1'b1;
        mem_addr  = OUT_LO_ADDR;
        mem_wdata = result[7:0];
        state_nxt = WR_HI;
      end
      WR_HI: begin
        mem_we    = 1'b1;
        mem_addr  = OUT_LO_ADDR + 8'd1;
        mem_wdata = result[15:8];
        state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fix2flt_conv.sv
// Scoreboard bench for fix2flt_conv: stimulus queues expected results, a monitor checks on done.
module tb_fix2flt_conv;

  localparam logic [7:0] OUT_A = 8'd4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic       busy;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;

  logic [7:0] mem [256];
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;

  int cyc = 0;
  int wr_cnt = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] din;
    logic [15:0] res;
    int          lat;
    int          c0;
  } exp_t;
  exp_t sbq[$];

  fix2flt_conv #(.IN_LO_ADDR(8'd0), .OUT_LO_ADDR(OUT_A)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: pops one expectation per done pulse and checks result, latency and busy.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        wr_cnt++;
        chk("write_addr_range", 32'(mem_addr == OUT_A || mem_addr == OUT_A + 8'd1), 32'd1);
      end
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk($sformatf("result_%04h", e.din), 32'({mem[OUT_A + 8'd1], mem[OUT_A]}), 32'(e.res));
          chk($sformatf("latency_%04h", e.din), 32'(cyc - e.c0), 32'(e.lat));
          chk($sformatf("busy_at_done_%04h", e.din), 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic launch(input logic [15:0] din);
    load(8'd0, din[7:0]);
    load(8'd1, din[15:8]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      chk("done_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [15:0] din, input logic [15:0] res, input int n, input bit toggle);
    launch(din);
    sbq.push_back('{din: din, res: res, lat: 8 + n, c0: cyc});
    if (toggle) begin
      repeat (3) @(negedge clk);
      start = 1'b1; @(negedge clk);
      start = 1'b0; @(negedge clk);
      start = 1'b1; @(negedge clk);
      start = 1'b0;
    end
    drain();
  endtask

  initial begin
    int w0;
    logic [15:0] held;
    reset = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run(16'h0100, 16'h3C00, 7, 1'b0);
    run(16'hFF00, 16'hBC00, 7, 1'b0);
    run(16'h0000, 16'h0000, 0, 1'b0);
    run(16'h8000, 16'hD800, 0, 1'b0);
    run(16'h0001, 16'h1C00, 15, 1'b0);
    run(16'hFF80, 16'hB800, 8, 1'b0);
    run(16'h1234, 16'h4C8D, 3, 1'b0);
`ifdef FIX2FLT_RNE_EN
    run(16'h7FFF, 16'h5800, 1, 1'b0);
    run(16'h0801, 16'h4800, 4, 1'b0);
    run(16'h0803, 16'h4802, 4, 1'b0);
`else
    run(16'h7FFF, 16'h57FF, 1, 1'b0);
    run(16'h0801, 16'h4800, 4, 1'b0);
    run(16'h0803, 16'h4801, 4, 1'b0);
`endif

    // Toggling start mid-conversion must not queue a second conversion.
    run(16'h0100, 16'h3C00, 7, 1'b1);
    repeat (25) @(negedge clk);
    chk("toggle_idle_busy", 32'(busy), 32'd0);

    // Reset while normalizing 2^-8: no done, no writes, previous result left intact.
    held = {mem[OUT_A + 8'd1], mem[OUT_A]};
    launch(16'h0001);
    repeat (8) @(negedge clk);
    chk("busy_in_norm", 32'(busy), 32'd1);
    w0 = wr_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("busy_after_reset", 32'(busy), 32'd0);
    chk("done_after_reset", 32'(done), 32'd0);
    repeat (30) @(negedge clk);
    chk("writes_after_reset", 32'(wr_cnt - w0), 32'd0);
    chk("out_after_reset", 32'({mem[OUT_A + 8'd1], mem[OUT_A]}), 32'(held));

    run(16'hFF00, 16'hBC00, 7, 1'b0);
    run(16'h0001, 16'h1C00, 15, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
